// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_pkg;

    // Controller phases: stream image in, one-cycle boot gap, core running.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } imem_state_e;

    // addi x0, x0, 0 -- harmless fetch while the image is not usable.
    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

    // Word depth of the instruction RAM for a given PC byte-address width.
    function automatic int imem_depth(input int ins_address);
        return 2 ** (ins_address - 2);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write port from the loader, asynchronous
// read port so the single-cycle core sees its instruction in the same cycle.
module imem_ram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write one loader word per accepted beat; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams a program image into the
// instruction RAM while holding the core in reset, then releases the core
// and serves zero-latency fetches at its PC.
// Optional build macro IMEM_CHECKSUM_EN adds a running XOR checksum of the
// accepted load words on csum; without it csum is tied to zero.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int               INS_ADDRESS = 9,
    parameter int               INS_W       = 32,
    parameter logic [INS_W-1:0] NOP_WORD    = INS_W'(IMEM_NOP_WORD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [INS_W-1:0]       ld_data,
    input  logic                   ld_last,
    input  logic                   reload,
    input  logic [INS_ADDRESS-1:0] pc,
    output logic [INS_W-1:0]       instr,
    output logic                   core_rst_n,
    output logic [1:0]             state,
    output logic [INS_ADDRESS-2:0] ld_count,
    output logic                   misalign_err,
    output logic [INS_W-1:0]       csum
);

    localparam int             DEPTH  = imem_depth(INS_ADDRESS);
    localparam int             AW     = INS_ADDRESS - 2;
    localparam int             CW     = INS_ADDRESS - 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH - 1);

    imem_state_e      state_reg, state_next;
    logic [CW-1:0]    ld_count_reg, ld_count_next;
    logic             misalign_reg;
    logic             core_rst_n_reg;
    logic             accept;
    logic             reload_entry;
    logic             pc_misaligned;
    logic [INS_W-1:0] ram_rdata;

    // Ready depends only on registered state, never on ld_valid.
    assign ld_ready      = (state_reg == ST_LOAD) && (ld_count_reg < CNT_FULL);
    assign accept        = ld_valid && ld_ready;
    assign reload_entry  = (state_reg == ST_RUN) && reload;
    assign pc_misaligned = (pc[1:0] != 2'b00);

    // Next-state: leave LOAD on the last word (flagged or RAM full), one BOOT cycle, RUN until reload.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: begin
                if (accept && (ld_last || (ld_count_reg == CNT_LAST))) begin
                    state_next = ST_BOOT;
                end
            end
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (reload) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Word counter: restarts on reload, counts accepted beats, saturates at depth.
    always_comb begin
        ld_count_next = ld_count_reg;
        if (reload_entry) begin
            ld_count_next = '0;
        end else if (accept && (ld_count_reg != CNT_FULL)) begin
            ld_count_next = ld_count_reg + 1'b1;
        end
    end

    // State, counter, core reset and sticky misalignment registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_LOAD;
            ld_count_reg   <= '0;
            core_rst_n_reg <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ld_count_reg   <= ld_count_next;
            core_rst_n_reg <= (state_next == ST_RUN);
            misalign_reg   <= misalign_reg || ((state_reg == ST_RUN) && pc_misaligned);
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [INS_W-1:0] csum_reg;

    // Running XOR of accepted words; frozen outside LOAD since nothing is accepted there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_reg <= '0;
        end else if (reload_entry) begin
            csum_reg <= '0;
        end else if (accept) begin
            csum_reg <= csum_reg ^ ld_data;
        end
    end

    assign csum = csum_reg;
`else
    assign csum = '0;
`endif

    imem_ram #(
        .ADDR_W (AW),
        .DATA_W (INS_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (ld_count_reg[AW-1:0]),
        .wdata (ld_data),
        .raddr (pc[INS_ADDRESS-1:2]),
        .rdata (ram_rdata)
    );

    // Fetch path: RAM word only for aligned PCs while running, otherwise NOP.
    assign instr        = ((state_reg == ST_RUN) && !pc_misaligned) ? ram_rdata : NOP_WORD;
    assign core_rst_n   = core_rst_n_reg;
    assign state        = state_reg;
    assign ld_count     = ld_count_reg;
    assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a scoreboard queue and negedge monitor.
module tb_imem_load_ctrl;

    localparam int SIG_INSTR = 0;
    localparam int SIG_READY = 1;
    localparam int SIG_CRST  = 2;
    localparam int SIG_STATE = 3;
    localparam int SIG_COUNT = 4;
    localparam int SIG_MISAL = 5;
    localparam int SIG_CSUM  = 6;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        reload = 1'b0;
    logic [8:0]  pc = '0;
    logic [31:0] instr;
    logic        core_rst_n;
    logic [1:0]  state;
    logic [7:0]  ld_count;
    logic        misalign_err;
    logic [31:0] csum;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    imem_load_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .reload       (reload),
        .pc           (pc),
        .instr        (instr),
        .core_rst_n   (core_rst_n),
        .state        (state),
        .ld_count     (ld_count),
        .misalign_err (misalign_err),
        .csum         (csum)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            SIG_INSTR: return instr;
            SIG_READY: return {31'b0, ld_ready};
            SIG_CRST:  return {31'b0, core_rst_n};
            SIG_STATE: return {30'b0, state};
            SIG_COUNT: return {24'b0, ld_count};
            SIG_MISAL: return {31'b0, misalign_err};
            SIG_CSUM:  return csum;
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: drain every pending expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = sample(e.sig);
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end else begin
                $display("ok   %s: 0x%08h", e.name, act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sig, input logic [31:0] exp, input string name);
        sb_q.push_back('{sig, exp, name});
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        pc    = 9'h004;
        chk(SIG_STATE, 32'd0, "reset_state");
        chk(SIG_COUNT, 32'd0, "reset_ld_count");
        chk(SIG_CRST,  32'd0, "reset_core_rst_n");
        chk(SIG_MISAL, 32'd0, "reset_misalign");
        chk(SIG_CSUM,  32'd0, "reset_csum");
        chk(SIG_READY, 32'd1, "reset_ld_ready");
        chk(SIG_INSTR, NOP,   "reset_instr_nop");
        tick();

        // Three-word image, last flagged on the third
        send_beat(32'h0010_0093, 1'b0);
        send_beat(32'h0020_0113, 1'b0);
        chk(SIG_COUNT, 32'd2, "load1_count_mid");
        send_beat(32'h0020_8433, 1'b1);
        chk(SIG_STATE, 32'd1, "load1_boot_state");
        chk(SIG_COUNT, 32'd3, "load1_count");
        chk(SIG_READY, 32'd0, "load1_boot_ready");
        chk(SIG_CRST,  32'd0, "load1_boot_core_rst");
        chk(SIG_INSTR, NOP,   "load1_boot_instr_nop");
        tick();
        chk(SIG_STATE, 32'd2, "load1_run_state");
        chk(SIG_CRST,  32'd1, "load1_run_core_rst");
        chk(SIG_READY, 32'd0, "load1_run_ready");
        chk(SIG_INSTR, 32'h0020_0113, "load1_pc004");
        tick();
        pc = 9'h000;
        chk(SIG_INSTR, 32'h0010_0093, "load1_pc000");
        tick();

        // Reload with gaps; ld_last without ld_valid must be ignored
        do_reload();
        pc = 9'h008;
        chk(SIG_STATE, 32'd0, "reload2_state");
        chk(SIG_COUNT, 32'd0, "reload2_count");
        chk(SIG_CRST,  32'd0, "reload2_core_rst");
        chk(SIG_CSUM,  32'd0, "reload2_csum_clear");
        chk(SIG_INSTR, NOP,   "reload2_load_instr_nop");
        tick();
        tick();
        chk(SIG_COUNT, 32'd0, "gap_no_write");
        send_beat(32'h0000_FFFF, 1'b0);
        ld_last = 1'b1;
        tick();
        ld_last = 1'b0;
        chk(SIG_STATE, 32'd0, "last_without_valid_state");
        chk(SIG_COUNT, 32'd1, "last_without_valid_count");
        tick();
        send_beat(32'h00FF_00FF, 1'b1);
        chk(SIG_STATE, 32'd1, "load2_boot_state");
        chk(SIG_COUNT, 32'd2, "load2_count");
`ifdef IMEM_CHECKSUM_EN
        chk(SIG_CSUM, 32'h00FF_FF00, "load2_csum");
`else
        chk(SIG_CSUM, 32'h0000_0000, "load2_csum_off");
`endif
        tick();
        chk(SIG_INSTR, 32'h0020_8433, "load2_pc008_retained");
        tick();
        pc = 9'h000;
        chk(SIG_INSTR, 32'h0000_FFFF, "load2_pc000");
`ifdef IMEM_CHECKSUM_EN
        chk(SIG_CSUM, 32'h00FF_FF00, "load2_csum_frozen");
`else
        chk(SIG_CSUM, 32'h0000_0000, "load2_csum_off_run");
`endif
        tick();
        pc = 9'h004;
        chk(SIG_INSTR, 32'h00FF_00FF, "load2_pc004");
        tick();

        // Misaligned fetch
        pc = 9'h006;
        chk(SIG_INSTR, NOP,   "misalign_instr_nop");
        chk(SIG_MISAL, 32'd0, "misalign_not_yet");
        tick();
        chk(SIG_MISAL, 32'd1, "misalign_set");
        pc = 9'h008;
        tick();
        chk(SIG_MISAL, 32'd1, "misalign_sticky");
        chk(SIG_INSTR, 32'h0020_8433, "misalign_pc008");
        tick();

        // Reload and load a single word
        do_reload();
        chk(SIG_CRST, 32'd0, "reload3_core_rst_low");
        send_beat(32'hDEAD_BEEF, 1'b1);
        chk(SIG_CRST, 32'd0, "reload3_boot_core_rst_low");
        tick();
        pc = 9'h000;
        chk(SIG_INSTR, 32'hDEAD_BEEF, "reload3_pc000");
        chk(SIG_MISAL, 32'd1, "reload3_misalign_held");
        tick();
        pc = 9'h004;
        chk(SIG_INSTR, 32'h00FF_00FF, "reload3_pc004_retained");
        tick();

        // Abort a load with rst_n; written words persist
        do_reload();
        send_beat(32'hA000_0000, 1'b0);
        send_beat(32'hA111_1111, 1'b0);
        chk(SIG_COUNT, 32'd2, "abort_count_before");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk(SIG_COUNT, 32'd0, "abort_count_reset");
        chk(SIG_STATE, 32'd0, "abort_state");
        chk(SIG_MISAL, 32'd0, "abort_misalign_cleared");
        tick();
        send_beat(32'hCCCC_CCCC, 1'b1);
        tick();
        pc = 9'h000;
        chk(SIG_INSTR, 32'hCCCC_CCCC, "abort_pc000");
        tick();
        pc = 9'h004;
        chk(SIG_INSTR, 32'hA111_1111, "abort_pc004_retained");
        tick();

        // Full 128-word image without ld_last
        do_reload();
        for (int i = 0; i < 128; i++) begin
            if (i == 127) begin
                chk(SIG_STATE, 32'd0,   "full_state_before_last");
                chk(SIG_COUNT, 32'd127, "full_count_before_last");
                chk(SIG_READY, 32'd1,   "full_ready_before_last");
            end
            send_beat(32'h1000_0000 + i, 1'b0);
        end
        chk(SIG_STATE, 32'd1,   "full_boot_state");
        chk(SIG_COUNT, 32'd128, "full_count_saturated");
        chk(SIG_READY, 32'd0,   "full_ready_low");
        send_beat(32'h0BAD_0BAD, 1'b0);
        chk(SIG_COUNT, 32'd128, "full_129th_rejected");
        chk(SIG_STATE, 32'd2,   "full_run_state");
        pc = 9'h1FC;
        chk(SIG_INSTR, 32'h1000_007F, "full_pc1fc");
        tick();
        pc = 9'h000;
        chk(SIG_INSTR, 32'h1000_0000, "full_pc000");
        tick();
        tick();

        if (sb_q.size() != 0) begin
            n_err += sb_q.size();
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
